// File: rtl/div_seq.sv
// Sequential 32-bit divider: one restoring shift-subtract step per cycle, signed or unsigned.
// result_o = {remainder, quotient}; divide-by-zero yields an all-zero result after one cycle.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] divisor_q;
  logic        neg_quo;
  logic        neg_rem;

  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
  always_comb begin
    dividend_abs = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    divisor_abs  = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    shifted      = {rem_q, quo_q[31]};
    diff         = shifted - {1'b0, divisor_q};
    quo_fix      = neg_quo ? -quo_q : quo_q;
    rem_fix      = neg_rem ? -rem_q : rem_q;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FREE;
      cnt       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            busy_o <= 1'b1;
            if (opdata2_i == 32'h0) begin
              state <= BYZERO;
            end else begin
              state     <= ON;
              cnt       <= '0;
              quo_q     <= dividend_abs;
              rem_q     <= '0;
              divisor_q <= divisor_abs;
              neg_quo   <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
              neg_rem   <= signed_div_i && opdata1_i[31];
            end
          end
        end

        BYZERO: begin
          busy_o <= 1'b0;
          cnt    <= '0;
          if (annul_i) begin
            state <= FREE;
          end else begin
            state    <= END;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end

        ON: begin
          if (annul_i) begin
            state  <= FREE;
            busy_o <= 1'b0;
            cnt    <= '0;
          end else if (cnt != 6'd32) begin
            // Restoring step: keep the subtraction only if it did not borrow.
            if (!diff[32]) begin
              rem_q <= diff[31:0];
              quo_q <= {quo_q[30:0], 1'b1};
            end else begin
              rem_q <= shifted[31:0];
              quo_q <= {quo_q[30:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
          end else begin
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
            cnt      <= '0;
            state    <= END;
          end
        end

        END: begin
          // Result is held until EX drops start_i; annul_i cannot discard it.
          if (!start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end

        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: scoreboard of expected {rem, quo} values
// pushed at stimulus time and popped when ready_o rises.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Drive one request and wait for ready_o; lat = edges after E0, -1 on timeout.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [63:0] res, output int lat, output bit busy_ok);
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    start_i      = 1'b1;
    exp_q.push_back(model(a, b, sgn));
    @(posedge clk);
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      if (ready_o) begin
        lat = k;
        break;
      end
      if (!busy_o) busy_ok = 1'b0;
      @(posedge clk);
    end
    res = result_o;
  endtask

  task automatic release_start(output logic rdy, output logic [63:0] res, output logic bsy);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rdy = ready_o;
    res = result_o;
    bsy = busy_o;
  endtask

  task automatic check_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input int exp_lat);
    logic [63:0] res, exp, r2;
    int lat;
    bit bok;
    logic rdy, bsy;
    do_div(a, b, sgn, res, lat, bok);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (res !== exp) begin
      n_fail++;
      $display("FAIL %s result: got %h want %h", name, res, exp);
    end
    n_checks++;
    if (!bok) begin
      n_fail++;
      $display("FAIL %s busy: got 0 during division want 1", name);
    end
    release_start(rdy, r2, bsy);
    n_checks++;
    if (rdy !== 1'b0 || r2 !== 64'h0 || bsy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: got ready=%b result=%h busy=%b want 0/0/0", name, rdy, r2, bsy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset: got ready=%b busy=%b result=%h want 0/0/0", ready_o, busy_o, result_o);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic;
    logic [63:0] res, exp;
    int lat;
    bit bok;
    do_div(32'd7, 32'd2, 1'b0, res, lat, bok);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat != 33 || res !== {32'h1, 32'h3} || res !== exp || !bok) begin
      n_fail++;
      $display("FAIL divu_7_2: got lat=%0d res=%h busy_ok=%0b want 33 %h 1", lat, res, bok, exp);
    end
    // start still held: END holds result and ignores annul_i
    annul_i = 1'b1;
    repeat (2) @(negedge clk);
    annul_i = 1'b0;
    n_checks++;
    if (ready_o !== 1'b1 || result_o !== {32'h1, 32'h3} || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL end_hold: got ready=%b result=%h busy=%b want 1 %h 0",
               ready_o, result_o, busy_o, {32'h1, 32'h3});
    end
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++;
      $display("FAIL end_exit: got ready=%b result=%h want 0 0", ready_o, result_o);
    end
  endtask

  task automatic test_signed;
    check_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33);
    check_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 33);
    check_div("div_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33);
    check_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 33);
    check_div("divu_big", 32'hF000_0001, 32'h0001_0003, 1'b0, 33);
  endtask

  task automatic test_div_by_zero;
    check_div("divu_5_0", 32'd5, 32'd0, 1'b0, 1);
  endtask

  task automatic test_annul;
    bit seen_ready = 1'b0;
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL annul: got busy=%b ready=%b want 0 0", busy_o, ready_o);
    end
    // annul_i beats start_i in FREE
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL annul_priority: got busy=%b want 0", busy_o);
    end
    annul_i = 1'b0; start_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_o) seen_ready = 1'b1;
    end
    n_checks++;
    if (seen_ready) begin
      n_fail++;
      $display("FAIL annul_no_ready: got ready=1 want 0");
    end
    check_div("divu_9_3", 32'd9, 32'd3, 1'b0, 33);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    opdata1_i = 32'd555; opdata2_i = 32'd4; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2;
    start_i = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b ready=%b result=%h want 0/0/0", busy_o, ready_o, result_o);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b ready=%b want 0 0", busy_o, ready_o);
    end
    check_div("divu_100_7", 32'd100, 32'd7, 1'b0, 33);
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    logic sgn;
    for (int i = 0; i < 6; i++) begin
      a   = $urandom;
      b   = (i == 3) ? 32'h0 : ($urandom >> (i * 5));
      sgn = i[0];
      check_div($sformatf("rand_%0d", i), a, b, sgn, (b == 32'h0) ? 1 : 33);
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_by_zero();
    test_annul();
    test_async_reset();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
